// File: rtl/botao_debounce_if.sv
// Button debouncer bus: raw button and service acknowledge toward the
// debouncer, clean press pulse / pending flag / press counter back out.
interface botao_debounce_if;
    logic       bt_raw;
    logic       ack;
    logic       bt;
    logic       pend;
    logic [7:0] presses;

    // Driver side (button source plus downstream acknowledge)
    modport master (
        output bt_raw,
        output ack,
        input  bt,
        input  pend,
        input  presses
    );

    // Debouncer side
    modport slave (
        input  bt_raw,
        input  ack,
        output bt,
        output pend,
        output presses
    );
endinterface

// File: rtl/botao_debounce.sv
// Pedestrian button debouncer.
// The raw button is synchronised through two flops. A four-state FSM then
// accepts a level change only after DB_CYCLES consecutive equal samples.
// Each accepted press produces a one-cycle bt pulse, sets the pending flag
// (cleared by ack) and bumps a saturating press counter.
// Optional build macro BOTAO_LOCKOUT_EN: a press accepted while a request is
// still pending produces no pulse and no count; the FSM still tracks the
// button so the release is handled normally.
module botao_debounce #(
    parameter logic [7:0] DB_CYCLES = 8'd3
) (
    input  logic              clk,
    input  logic              rst,
    botao_debounce_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        CONF_PRESS,
        PRESSED,
        CONF_REL
    } state_t;

    localparam logic [7:0] LP_LAST = DB_CYCLES - 8'd1;

    logic       r_sync1;
    logic       r_sync2;
    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       w_accept;
    logic       w_pulse;
    logic       r_bt;
    logic       r_pend;
    logic [7:0] r_presses;

    // Two-flop synchroniser for the asynchronous button input
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.bt_raw;
            r_sync2 <= r_sync1;
        end
    end

    // State and stable-sample counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: qualify press and release over DB_CYCLES samples
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_sync2) begin
                    if (DB_CYCLES == 8'd1) begin
                        w_state_nxt = PRESSED;
                        w_cnt_nxt   = '0;
                        w_accept    = 1'b1;
                    end else begin
                        w_state_nxt = CONF_PRESS;
                        w_cnt_nxt   = 8'd1;
                    end
                end
            end
            CONF_PRESS: begin
                if (!r_sync2) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LP_LAST) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                    w_accept    = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + 8'd1;
                end
            end
            PRESSED: begin
                if (!r_sync2) begin
                    if (DB_CYCLES == 8'd1) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = CONF_REL;
                        w_cnt_nxt   = 8'd1;
                    end
                end
            end
            CONF_REL: begin
                if (r_sync2) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LP_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Accepted press becomes a visible pulse unless locked out by a pending request
    always_comb begin
`ifdef BOTAO_LOCKOUT_EN
        w_pulse = w_accept & ~r_pend;
`else
        w_pulse = w_accept;
`endif
    end

    // Output registers: press pulse, pending flag (new press beats ack), counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bt      <= 1'b0;
            r_pend    <= 1'b0;
            r_presses <= '0;
        end else begin
            r_bt <= w_pulse;
            if (w_accept) begin
                r_pend <= 1'b1;
            end else if (bus.ack) begin
                r_pend <= 1'b0;
            end
            if (w_pulse && (r_presses != '1)) begin
                r_presses <= r_presses + 8'd1;
            end
        end
    end

    assign bus.bt      = r_bt;
    assign bus.pend    = r_pend;
    assign bus.presses = r_presses;

endmodule

// File: tb/tb_botao_debounce.sv
// Self-checking bench for botao_debounce: two instances (DB_CYCLES=3 and 1)
// share stimulus; a run-length reference model predicts every output.
module tb_botao_debounce;

    localparam int N = 2;
`ifdef BOTAO_LOCKOUT_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic raw;
    logic ackv;

    always #5 clk = ~clk;

    botao_debounce_if bus_a ();
    botao_debounce_if bus_b ();

    assign bus_a.bt_raw = raw;
    assign bus_a.ack    = ackv;
    assign bus_b.bt_raw = raw;
    assign bus_b.ack    = ackv;

    botao_debounce #(.DB_CYCLES(8'd3)) u_db3 (.clk(clk), .rst(rst), .bus(bus_a));
    botao_debounce #(.DB_CYCLES(8'd1)) u_db1 (.clk(clk), .rst(rst), .bus(bus_b));

    logic       o_bt [N];
    logic       o_pend [N];
    logic [7:0] o_pr [N];
    assign o_bt[0] = bus_a.bt;
    assign o_bt[1] = bus_b.bt;
    assign o_pend[0] = bus_a.pend;
    assign o_pend[1] = bus_b.pend;
    assign o_pr[0] = bus_a.presses;
    assign o_pr[1] = bus_b.presses;

    int checks = 0;
    int errors = 0;

    // Reference model: debounced level flips once the synchronised input has
    // held the opposite value for db consecutive samples.
    int db [N] = '{3, 1};
    bit m_s1 [N];
    bit m_s2 [N];
    bit m_level [N];
    bit m_last [N];
    int m_run [N];
    bit m_bt [N];
    bit m_pend [N];
    int m_presses [N];

    task automatic tick(input logic r, input logic a, input logic n);
        bit v;
        bit acc;
        bit pulse;
        raw  = r;
        ackv = a;
        rst  = n;
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            if (!n) begin
                m_s1[k] = 0; m_s2[k] = 0; m_level[k] = 0; m_last[k] = 0;
                m_run[k] = 0; m_bt[k] = 0; m_pend[k] = 0; m_presses[k] = 0;
            end else begin
                v = m_s2[k];
                acc = 0;
                if (v == m_last[k]) begin
                    if (m_run[k] < 1000) m_run[k]++;
                end else begin
                    m_last[k] = v;
                    m_run[k]  = 1;
                end
                if (v != m_level[k] && m_run[k] >= db[k]) begin
                    m_level[k] = v;
                    acc = v;
                end
                pulse = acc && !(LOCK && m_pend[k]);
                m_bt[k] = pulse;
                if (pulse && m_presses[k] < 255) m_presses[k]++;
                if (acc) m_pend[k] = 1;
                else if (a) m_pend[k] = 0;
                m_s2[k] = m_s1[k];
                m_s1[k] = r;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) tick(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < N; k++) begin
            checks++;
            if (o_bt[k] !== 1'b0) begin errors++; $display("FAIL rst_bt[%0d] got %b exp 0", k, o_bt[k]); end
            checks++;
            if (o_pend[k] !== 1'b0) begin errors++; $display("FAIL rst_pend[%0d] got %b exp 0", k, o_pend[k]); end
            checks++;
            if (o_pr[k] !== 8'd0) begin errors++; $display("FAIL rst_presses[%0d] got %0d exp 0", k, o_pr[k]); end
        end
    endtask

    task automatic test_latency();
        int first [N];
        int pulses [N];
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < N; k++) begin first[k] = -1; pulses[k] = 0; end
        for (int e = 1; e <= 10; e++) begin
            tick(1'b1, 1'b0, 1'b1);
            for (int k = 0; k < N; k++) begin
                if (o_bt[k] === 1'b1) begin
                    pulses[k]++;
                    if (first[k] < 0) first[k] = e;
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (pulses[k] != 1) begin errors++; $display("FAIL lat_pulses[%0d] got %0d exp 1", k, pulses[k]); end
            checks++;
            if (first[k] != db[k] + 2) begin errors++; $display("FAIL lat_edge[%0d] got %0d exp %0d", k, first[k], db[k] + 2); end
            checks++;
            if (o_pr[k] !== 8'd1) begin errors++; $display("FAIL lat_presses[%0d] got %0d exp 1", k, o_pr[k]); end
            checks++;
            if (o_pend[k] !== 1'b1) begin errors++; $display("FAIL lat_pend[%0d] got %b exp 1", k, o_pend[k]); end
        end
    endtask

    task automatic test_short_bounce();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b0);
        for (int e = 0; e < 10; e++) begin
            tick((e < 2) ? 1'b1 : 1'b0, 1'b0, 1'b1);
            if (o_bt[0] === 1'b1) pulses++;
            for (int k = 0; k < N; k++) begin
                checks++;
                if (o_bt[k] !== m_bt[k]) begin errors++; $display("FAIL short_bt[%0d] cyc %0d got %b exp %b", k, e, o_bt[k], m_bt[k]); end
            end
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL short_pulses got %0d exp 0", pulses); end
        checks++;
        if (o_pr[0] !== 8'd0) begin errors++; $display("FAIL short_presses got %0d exp 0", o_pr[0]); end
        checks++;
        if (o_pend[0] !== 1'b0) begin errors++; $display("FAIL short_pend got %b exp 0", o_pend[0]); end
    endtask

    task automatic test_release_bounce();
        logic pat [4];
        int pulses;
        int first;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0;
        pulses = 0;
        first  = -1;
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b0);
        for (int e = 0; e < 8; e++) begin tick(1'b1, 1'b0, 1'b1); if (o_bt[0] === 1'b1) pulses++; end
        for (int e = 0; e < 4; e++) begin tick(pat[e], 1'b0, 1'b1); if (o_bt[0] === 1'b1) pulses++; end
        for (int e = 0; e < 8; e++) begin tick(1'b0, 1'b0, 1'b1); if (o_bt[0] === 1'b1) pulses++; end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL relb_pulses got %0d exp 1", pulses); end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (o_pr[k] !== 8'(m_presses[k])) begin errors++; $display("FAIL relb_presses[%0d] got %0d exp %0d", k, o_pr[k], m_presses[k]); end
        end
        // Back in IDLE: a fresh hold must qualify with the full latency
        for (int e = 1; e <= 8; e++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (o_bt[0] === 1'b1 && first < 0) first = e;
        end
        checks++;
        if (first != db[0] + 2) begin errors++; $display("FAIL relb_idle_edge got %0d exp %0d", first, db[0] + 2); end
    endtask

    task automatic test_ack();
        logic [7:0] exp_pr;
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b0);
        for (int e = 0; e < 6; e++) tick(1'b1, 1'b0, 1'b1);
        for (int e = 0; e < 8; e++) tick(1'b0, 1'b0, 1'b1);
        // Second press with ack landing on the same edge that accepts it (db=3 instance)
        for (int e = 1; e <= 6; e++) tick(1'b1, (e == db[0] + 2) ? 1'b1 : 1'b0, 1'b1);
        checks++;
        if (o_pend[0] !== 1'b1) begin errors++; $display("FAIL ack_same_edge_pend got %b exp 1", o_pend[0]); end
        checks++;
        if (o_pend[1] !== m_pend[1]) begin errors++; $display("FAIL ack_model_pend[1] got %b exp %b", o_pend[1], m_pend[1]); end
        for (int e = 0; e < 8; e++) tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        exp_pr = LOCK ? 8'd1 : 8'd2;
        for (int k = 0; k < N; k++) begin
            checks++;
            if (o_pend[k] !== 1'b0) begin errors++; $display("FAIL ack_clear_pend[%0d] got %b exp 0", k, o_pend[k]); end
            checks++;
            if (o_pr[k] !== exp_pr) begin errors++; $display("FAIL ack_presses[%0d] got %0d exp %0d", k, o_pr[k], exp_pr); end
            checks++;
            if (o_bt[k] !== 1'b0) begin errors++; $display("FAIL ack_idle_bt[%0d] got %b exp 0", k, o_bt[k]); end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b0);
        for (int p = 0; p < 260; p++) begin
            for (int e = 0; e < 6; e++) tick(1'b1, 1'b0, 1'b1);
            for (int e = 0; e < 6; e++) tick(1'b0, (e == 5) ? 1'b1 : 1'b0, 1'b1);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (o_pr[k] !== 8'd255) begin errors++; $display("FAIL sat_presses[%0d] got %0d exp 255", k, o_pr[k]); end
            checks++;
            if (o_pend[k] !== 1'b0) begin errors++; $display("FAIL sat_pend[%0d] got %b exp 0", k, o_pend[k]); end
        end
    endtask

    task automatic test_back_to_back();
        int pulses [N];
        int exp_n;
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < N; k++) pulses[k] = 0;
        for (int p = 0; p < 2; p++) begin
            for (int e = 0; e < 12; e++) begin
                tick((e < 6) ? 1'b1 : 1'b0, 1'b0, 1'b1);
                for (int k = 0; k < N; k++) if (o_bt[k] === 1'b1) pulses[k]++;
            end
        end
        exp_n = LOCK ? 1 : 2;
        for (int k = 0; k < N; k++) begin
            checks++;
            if (pulses[k] != exp_n) begin errors++; $display("FAIL b2b_pulses[%0d] got %0d exp %0d", k, pulses[k], exp_n); end
            checks++;
            if (o_pr[k] !== 8'(exp_n)) begin errors++; $display("FAIL b2b_presses[%0d] got %0d exp %0d", k, o_pr[k], exp_n); end
        end
    endtask

    task automatic test_reset_mid();
        int first [N];
        int early;
        early = 0;
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b0);
        for (int e = 0; e < 8; e++) tick(1'b0, 1'b0, 1'b1);
        for (int e = 0; e < 3; e++) tick(1'b1, 1'b0, 1'b1);
        if (o_bt[0] === 1'b1) early++;
        tick(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < N; k++) begin
            checks++;
            if ({o_bt[k], o_pend[k], o_pr[k]} !== 10'd0) begin
                errors++;
                $display("FAIL midrst_outs[%0d] got bt=%b pend=%b presses=%0d exp all 0", k, o_bt[k], o_pend[k], o_pr[k]);
            end
            first[k] = -1;
        end
        checks++;
        if (early != 0) begin errors++; $display("FAIL midrst_early_pulse got %0d exp 0", early); end
        for (int e = 1; e <= 8; e++) begin
            tick(1'b1, 1'b0, 1'b1);
            for (int k = 0; k < N; k++) if (o_bt[k] === 1'b1 && first[k] < 0) first[k] = e;
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (first[k] != db[k] + 2) begin errors++; $display("FAIL midrst_requal_edge[%0d] got %0d exp %0d", k, first[k], db[k] + 2); end
        end
    endtask

    task automatic test_random();
        logic lvl;
        logic a;
        logic n;
        int len;
        int cyc;
        cyc = 0;
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b0);
        while (cyc < 1500) begin
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++) begin
                n = ($urandom_range(0, 199) != 0);
                a = ($urandom_range(0, 7) == 0);
                tick(lvl, a, n);
                cyc++;
                for (int k = 0; k < N; k++) begin
                    checks++;
                    if (o_bt[k] !== m_bt[k]) begin errors++; $display("FAIL rnd_bt[%0d] cyc %0d got %b exp %b", k, cyc, o_bt[k], m_bt[k]); end
                    checks++;
                    if (o_pend[k] !== m_pend[k]) begin errors++; $display("FAIL rnd_pend[%0d] cyc %0d got %b exp %b", k, cyc, o_pend[k], m_pend[k]); end
                    checks++;
                    if (o_pr[k] !== 8'(m_presses[k])) begin errors++; $display("FAIL rnd_presses[%0d] cyc %0d got %0d exp %0d", k, cyc, o_pr[k], m_presses[k]); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_short_bounce();
        test_release_bounce();
        test_ack();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/botao_debounce.md
BOTAO_DEBOUNCE -- requirements
Module: botao_debounce

Interface
REQ-001 The module SHALL have parameter DB_CYCLES, default 8'd3, meaning the number of consecutive synchronized samples needed to accept a level change (legal 1..255).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous active-low reset, sampled on rising clk.
REQ-004 The module SHALL have port bt_raw, input, 1 bit: raw, asynchronous, bouncing pedestrian button.
REQ-005 The module SHALL have port ack, input, 1 bit: from the downstream semaforo; the pending request has been served.
REQ-006 The module SHALL have port bt, output, 1 bit: one-cycle clean press pulse, wired to the semaforo bt input.
REQ-007 The module SHALL have port pend, output, 1 bit: a request is waiting for service.
REQ-008 The module SHALL have port presses, output, 8 bits: count of accepted presses, saturating.

Function
REQ-009 bt_raw SHALL pass through a 2-flop synchronizer; only the second flop (sync) SHALL feed the FSM.
REQ-010 The FSM SHALL have four states: IDLE, CONF_PRESS, PRESSED, CONF_REL; an 8-bit counter cnt SHALL count stable samples.
REQ-011 In IDLE with sync=1, the FSM SHALL move to CONF_PRESS with cnt=1; with DB_CYCLES=1 it SHALL instead go directly to PRESSED and accept the press.
REQ-012 In CONF_PRESS: sync=0 SHALL go to IDLE with cnt=0; sync=1 with cnt==DB_CYCLES-1 SHALL go to PRESSED and accept the press; otherwise cnt SHALL increment.
REQ-013 In PRESSED with sync=0, the FSM SHALL move to CONF_REL with cnt=1; with DB_CYCLES=1 it SHALL go directly to IDLE.
REQ-014 In CONF_REL: sync=1 SHALL return to PRESSED with no new press; sync=0 with cnt==DB_CYCLES-1 SHALL go to IDLE; otherwise cnt SHALL increment.
REQ-015 On an accepted press, bt SHALL be 1 for exactly one cycle, registered in the cycle the FSM enters PRESSED.
REQ-016 Latency: with bt_raw held high, bt SHALL rise on the (DB_CYCLES+2)th rising edge counting the first edge that samples bt_raw=1.
REQ-017 On an accepted press, pend SHALL be set; ack=1 SHALL clear pend on the next edge.
REQ-018 If ack=1 and a press is accepted on the same edge, pend SHALL remain 1 (the new press wins).
REQ-019 ack while pend=0 SHALL have no effect.
REQ-020 presses SHALL increment by 1 per accepted press and saturate at 8'd255 (no wrap).
REQ-021 Holding the button SHALL never generate more than one bt pulse; bounce shorter than DB_CYCLES samples SHALL generate none.

Reset
REQ-022 With rst=0 at a rising edge, the block SHALL load state=IDLE, cnt=0, both sync flops=0, bt=0, pend=0, presses=0.
REQ-023 Reset SHALL dominate ack and any in-progress qualification; a mid-confirmation press SHALL be discarded.
REQ-024 If the button is held through reset release, the press SHALL be requalified from scratch, and bt SHALL pulse DB_CYCLES+2 edges after the first edge with rst=1.

Configuration
REQ-025 If BOTAO_LOCKOUT_EN is defined, a press accepted while pend=1 SHALL produce no bt pulse and no presses increment; the FSM SHALL still track the button so that the release is handled.
REQ-026 If BOTAO_LOCKOUT_EN is undefined, every accepted press SHALL pulse bt and increment presses, regardless of pend.

Verification
REQ-027 DB_CYCLES=3, rst=0 for 2 cycles, then bt_raw=1 for 10 cycles -> single bt pulse at edge 5, presses=1, pend=1.
REQ-028 bt_raw=1 for 2 cycles then 0 -> bt never 1, presses=0, pend=0.
REQ-029 Held press, then release bouncing 1,0,1,0 per cycle, then 0 -> exactly one bt pulse in total, FSM ends in IDLE.
REQ-030 ack=1 on the same edge a second press is accepted -> pend=1 afterwards; ack alone on a later cycle -> pend=0.
REQ-031 260 clean presses -> presses=255.
REQ-032 Two presses with no ack -> two pulses and presses=2 without BOTAO_LOCKOUT_EN, one pulse and presses=1 with it; rst=0 asserted during CONF_PRESS -> no pulse and all outputs 0.
